alu_ctrl_seq: RTL and testbench

ALU_CTRL_SEQ -- requirements
Module: alu_ctrl_seq

---
 rtl/alu_ctrl_seq.sv | 176 +++++++++++++++++
 tb/tb_alu_ctrl_seq.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_seq.sv
//------------------------------------------------------------------------------
// Module   : alu_ctrl_seq
// Purpose  : Hardwired fetch/execute control sequencer for an ALU datapath.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_ctrl_seq (
    input  logic        clk,
    input  logic        clr,
    input  logic        run,
    input  logic [31:0] ir,
    output logic        pc_out,
    output logic        pc_increment,
    output logic        pc_in,
    output logic        mar_in,
    output logic        read,
    output logic        mdr_in,
    output logic        mdr_out,
    output logic        ir_in,
    output logic        y_in,
    output logic        zhigh_in,
    output logic        zlow_in,
    output logic        zhigh_out,
    output logic        zlow_out,
    output logic        hi_in,
    output logic        lo_in,
    output logic [4:0]  op_code,
    output logic [15:0] rin_sel,
    output logic [15:0] rout_sel,
    output logic        done,
    output logic        illegal
);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_DONE = 4'd8
    } state_t;

    state_t state_q, state_d;

    logic [4:0] w_op;
    logic [3:0] w_ra, w_rb, w_rc;
    logic       w_three, w_wide, w_two;
    logic       w_unused_ir;

    assign w_op        = ir[31:27];
    assign w_ra        = ir[26:23];
    assign w_rb        = ir[22:19];
    assign w_rc        = ir[18:15];
    assign w_unused_ir = ^ir[14:0];

    assign w_three = (w_op <= 5'b01000);
    assign w_wide  = (w_op == 5'b01111) || (w_op == 5'b10000);
    assign w_two   = (w_op == 5'b10001) || (w_op == 5'b10010);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_out       = 1'b0;
        pc_increment = 1'b0;
        pc_in        = 1'b0;
        mar_in       = 1'b0;
        read         = 1'b0;
        mdr_in       = 1'b0;
        mdr_out      = 1'b0;
        ir_in        = 1'b0;
        y_in         = 1'b0;
        zhigh_in     = 1'b0;
        zlow_in      = 1'b0;
        zhigh_out    = 1'b0;
        zlow_out     = 1'b0;
        hi_in        = 1'b0;
        lo_in        = 1'b0;
        op_code      = 5'b00000;
        rin_sel      = 16'h0000;
        rout_sel     = 16'h0000;
        done         = 1'b0;
        illegal      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_T0;
            end
            S_T0: begin
                pc_out       = 1'b1;
                pc_increment = 1'b1;
                mar_in       = 1'b1;
                zlow_in      = 1'b1;
                zhigh_in     = 1'b1;
                state_d      = S_T1;
            end
            S_T1: begin
                zlow_out = 1'b1;
                pc_in    = 1'b1;
                read     = 1'b1;
                mdr_in   = 1'b1;
                state_d  = S_T2;
            end
            S_T2: begin
                mdr_out = 1'b1;
                ir_in   = 1'b1;
                state_d = S_T3;
            end
            // IR is loaded at the end of T2, so decode starts here.
            S_T3: begin
                if (w_three || w_wide) begin
                    rout_sel = 16'h0001 << w_rb;
                    y_in     = 1'b1;
                    state_d  = S_T4;
                end else if (w_two) begin
                    rout_sel = 16'h0001 << w_rb;
                    op_code  = w_op;
                    zlow_in  = 1'b1;
                    zhigh_in = 1'b1;
                    state_d  = S_T4;
                end else begin
                    illegal  = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            S_T4: begin
                if (w_two) begin
                    zlow_out = 1'b1;
                    rin_sel  = 16'h0001 << w_ra;
                    state_d  = S_DONE;
                end else begin
                    rout_sel = 16'h0001 << w_rc;
                    op_code  = w_op;
                    zlow_in  = 1'b1;
                    zhigh_in = 1'b1;
                    state_d  = S_T5;
                end
            end
            S_T5: begin
                zlow_out = 1'b1;
                if (w_wide) begin
                    lo_in   = 1'b1;
                    state_d = S_T6;
                end else begin
                    rin_sel = 16'h0001 << w_ra;
                    state_d = S_DONE;
                end
            end
            S_T6: begin
                zhigh_out = 1'b1;
                hi_in     = 1'b1;
                state_d   = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = run ? S_T0 : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_ctrl_seq.sv
//------------------------------------------------------------------------------
// Module   : tb_alu_ctrl_seq
// Purpose  : Self-checking bench for alu_ctrl_seq against a micro-op table model.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu_ctrl_seq;

    logic        clk;
    logic        clr;
    logic        run;
    logic [31:0] ir;
    logic        pc_out, pc_increment, pc_in, mar_in, read, mdr_in, mdr_out, ir_in, y_in;
    logic        zhigh_in, zlow_in, zhigh_out, zlow_out, hi_in, lo_in;
    logic [4:0]  op_code;
    logic [15:0] rin_sel, rout_sel;
    logic        done, illegal;

    typedef struct packed {
        logic        pc_out, pc_increment, pc_in, mar_in, read, mdr_in, mdr_out, ir_in, y_in;
        logic        zhigh_in, zlow_in, zhigh_out, zlow_out, hi_in, lo_in, done, illegal;
        logic [4:0]  op_code;
        logic [15:0] rin_sel;
        logic [15:0] rout_sel;
    } ov_t;

    ov_t  obs;
    ov_t  exp_q[$];
    int   checks;
    int   failures;

    assign obs = {pc_out, pc_increment, pc_in, mar_in, read, mdr_in, mdr_out, ir_in, y_in,
                  zhigh_in, zlow_in, zhigh_out, zlow_out, hi_in, lo_in, done, illegal,
                  op_code, rin_sel, rout_sel};

    alu_ctrl_seq dut (
        .clk          (clk),
        .clr          (clr),
        .run          (run),
        .ir           (ir),
        .pc_out       (pc_out),
        .pc_increment (pc_increment),
        .pc_in        (pc_in),
        .mar_in       (mar_in),
        .read         (read),
        .mdr_in       (mdr_in),
        .mdr_out      (mdr_out),
        .ir_in        (ir_in),
        .y_in         (y_in),
        .zhigh_in     (zhigh_in),
        .zlow_in      (zlow_in),
        .zhigh_out    (zhigh_out),
        .zlow_out     (zlow_out),
        .hi_in        (hi_in),
        .lo_in        (lo_in),
        .op_code      (op_code),
        .rin_sel      (rin_sel),
        .rout_sel     (rout_sel),
        .done         (done),
        .illegal      (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Expected per-cycle outputs from T0 to the last cycle of the instruction.
    task automatic build_model(input logic [31:0] instr, output bit is_illegal);
        ov_t      e;
        int       op;
        int       ra, rb, rc;
        bit       three, wide, two;
        op    = int'(instr[31:27]);
        ra    = int'(instr[26:23]);
        rb    = int'(instr[22:19]);
        rc    = int'(instr[18:15]);
        three = (op <= 8);
        wide  = (op == 15) || (op == 16);
        two   = (op == 17) || (op == 18);
        is_illegal = !(three || wide || two);
        exp_q.delete();

        e = '0; e.pc_out = 1; e.pc_increment = 1; e.mar_in = 1; e.zlow_in = 1; e.zhigh_in = 1;
        exp_q.push_back(e);
        e = '0; e.zlow_out = 1; e.pc_in = 1; e.read = 1; e.mdr_in = 1;
        exp_q.push_back(e);
        e = '0; e.mdr_out = 1; e.ir_in = 1;
        exp_q.push_back(e);

        if (is_illegal) begin
            e = '0; e.illegal = 1;
            exp_q.push_back(e);
            return;
        end
        if (two) begin
            e = '0; e.rout_sel = 16'(1 << rb); e.op_code = 5'(op); e.zlow_in = 1; e.zhigh_in = 1;
            exp_q.push_back(e);
            e = '0; e.zlow_out = 1; e.rin_sel = 16'(1 << ra);
            exp_q.push_back(e);
        end else begin
            e = '0; e.rout_sel = 16'(1 << rb); e.y_in = 1;
            exp_q.push_back(e);
            e = '0; e.rout_sel = 16'(1 << rc); e.op_code = 5'(op); e.zlow_in = 1; e.zhigh_in = 1;
            exp_q.push_back(e);
            if (three) begin
                e = '0; e.zlow_out = 1; e.rin_sel = 16'(1 << ra);
                exp_q.push_back(e);
            end else begin
                e = '0; e.zlow_out = 1; e.lo_in = 1;
                exp_q.push_back(e);
                e = '0; e.zhigh_out = 1; e.hi_in = 1;
                exp_q.push_back(e);
            end
        end
        e = '0; e.done = 1;
        exp_q.push_back(e);
    endtask

    task automatic check_onehot();
        chk("rin_onehot",  64'($countones(rin_sel)  <= 1), 64'd1);
        chk("rout_onehot", 64'($countones(rout_sel) <= 1), 64'd1);
    endtask

    // Entered either from IDLE or from DONE with run already high (back-to-back).
    task automatic exec(input string tag, input logic [31:0] instr, input bit b2b,
                        input int exp_len);
        bit is_ill;
        int n;
        ov_t e;
        build_model(instr, is_ill);
        n = exp_q.size();
        if (exp_len > 0) chk({tag, "_latency"}, 64'(n), 64'(exp_len));
        ir  = instr;
        run = 1'b1;
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            e = exp_q[k];
            chk($sformatf("%s_c%0d", tag, k), 64'(obs), 64'(e));
            check_onehot();
            if (k < n - 1) run = 1'($urandom_range(0, 1));
        end
        if (is_ill) begin
            run = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            chk({tag, "_idle_after_illegal"}, 64'(obs), 64'd0);
            if (!b2b) run = 1'b0;
        end else if (!b2b) begin
            run = 1'b0;
            @(posedge clk); #1;
            chk({tag, "_idle_after_done"}, 64'(obs), 64'd0);
        end else begin
            run = 1'b1;
        end
    endtask

    initial begin
        logic [31:0] rnd;
        checks   = 0;
        failures = 0;
        clr = 1'b0;
        run = 1'b0;
        ir  = 32'h0;
        #12;
        chk("reset_outputs", 64'(obs), 64'd0);
        @(negedge clk); clr = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("idle_hold", 64'(obs), 64'd0);
        end

        // Asynchronous reset during instruction fetch.
        run = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("t1_read", 64'({read, mdr_in, pc_in}), 64'h7);
        clr = 1'b0;
        #1;
        chk("async_clr_t1", 64'({read, mdr_in, pc_in}), 64'h0);
        chk("async_clr_all", 64'(obs), 64'd0);
        run = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            chk("clr_held", 64'(obs), 64'd0);
        end
        @(negedge clk); clr = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("post_clr_idle", 64'(obs), 64'd0);
        end

        exec("neg",     32'h8C800000, 1'b0, 6);
        exec("add",     32'h11890000, 1'b0, 7);
        exec("mul",     32'h78228000, 1'b0, 8);
        exec("illegal", 32'hF8000000, 1'b0, 4);
        exec("b2b_neg1", 32'h8C800000, 1'b1, 6);
        exec("b2b_neg2", 32'h8C800000, 1'b0, 6);

        for (int i = 0; i < 60; i++) begin
            rnd = $urandom;
            exec($sformatf("rnd%0d", i), rnd, 1'($urandom_range(0, 1)), 0);
        end
        run = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("final_idle", 64'(obs), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
